top_level_dec: RTL and testbench
================================

Name: top_level_dec

Overview:
- RSA decryption engine: computes m = c^d mod n over W-bit operands.
- Counterpart of top_level_enc; a ciphertext from the encoder, decrypted with the matching private key, returns the original message.
- Sequential right-to-left square-and-multiply.
- Each modular product uses bit-serial interleaved shift/add/subtract, one multiplier bit per cycle.

Parameters:
- W, 128, operand width of cipher, d_key, n and m.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level request; sampled only in IDLE.
- cipher  input  W  ciphertext c; any value, including c >= n.
- d_key  input  W  private exponent d.
- n  input  W  modulus.
- m  output  W  decrypted message; registered.
- busy  output  1  high in REDUCE/CHECK/EXP.
- done  output  1  high only in DONE.

Behaviour:
- Reset (async, any state): state=IDLE, m=0, done=0, busy=0; internal result/base/exponent/accumulators cleared. An operation in flight is abandoned, with no partial m.
- start asserted during reset is not acted on; first rising edge after release with start=1 launches.
- IDLE, start=1 at edge E0:
  - latch cipher, d_key and n into internal registers; inputs are ignored until the next launch;
  - if n<2: go DONE with m=0 at E0+1;
  - else: go REDUCE.
- REDUCE: W cycles. base = cipher mod n, computed as modmul(cipher, 1); result = 1; exp = d_key. Then → CHECK.
- CHECK: 1 cycle.
  - exp==0 → DONE, m<=result;
  - else → EXP.
- EXP: W cycles, two multipliers in parallel:
  - P = result*base mod n;
  - S = base*base mod n.
  - On the last cycle: if exp[0], result<=P; base<=S; exp<=exp>>1. Then → CHECK.
- DONE: done=1, m held. Leave to IDLE on the first edge with start=0; stay while start=1, so a held start yields exactly one result.
- Latency: let L = bit length of d (0 if d=0). done rises (L+1)*(W+1) edges after E0. For d=0, m = 1 mod n.
- m changes only on entry to DONE or on reset; it holds its value through IDLE and the next operation until the new result.
- start while busy or in DONE: ignored; no restart.
- Modmul, interleaved, a scanned MSB→LSB over W cycles, requires b<n:
  - r = 2r; if r>=n then r -= n;
  - if a[i]: r += b; if r>=n then r -= n.
  - Intermediates are W+1 bits wide, so there is no overflow at W=128 with n up to 2^W-1.
  - The invariant r<n is maintained.

Decomposition:
- Shared package:
  - default W;
  - state encoding constants IDLE, REDUCE, CHECK, EXP, DONE;
  - cycle-count width, clog2(W).
- Sub-module mod_mult:
  - ports clk, reset, load, a, b, n, r;
  - W-cycle serial interleaved modular multiplier.
- Two mod_mult instances (product, square). The square instance also performs the REDUCE step with b=1.
- The controller owns the bit counter and the state machine.

Test Plan:
1. n=33, d_key=7, cipher=31, start held 1 → done rises 516 edges after launch (W=128), m=4, busy low in DONE.
2. Round trip: top_level_enc(message=920, e_key=33, n=2773) → feed its c with d_key=1617, n=2773 → m=920.
3. cipher=64 (>n), d_key=1, n=33 → m=31, latency 2*(W+1)=258.
4. d_key=0, n=33, cipher=5 → m=1 after W+1 edges. Separately, n=1 → m=0, done at E0+1.
5. Reset asserted mid-EXP of scenario 1 → m=0, done=0, busy=0 immediately (async). After release with start=1, a full run again gives m=4.
6. Start held high through DONE → done stays 1, no relaunch. Drop start for 1 cycle, change inputs mid-run and assert start → inputs change ignored; the new result appears only after the fresh launch.

Source files
------------

// File: rtl/top_level_dec_pkg.sv
// Shared constants and state encoding for the RSA decryption engine.
package top_level_dec_pkg;

    localparam int DEF_W = 128;
    localparam int CNT_W = $clog2(DEF_W);

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        CHECK,
        EXP,
        DONE
    } state_t;

endpackage

// File: rtl/top_level_dec_mod_mult.sv
// Bit-serial interleaved modular multiplier: r = a*b mod n over W cycles, MSB of a first.
// r is the combinational result of the current step; it is final on the W-th cycle after load.
module mod_mult
    import top_level_dec_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] r
);

    logic [W-1:0] acc;
    logic [W-1:0] a_sh;
    logic         bit_now;
    logic [W:0]   nx;
    logic [W:0]   t0;
    logic [W:0]   t1;
    logic [W:0]   t2;

    // The load cycle already performs the first step, starting from r = 0.
    always_comb begin
        nx      = {1'b0, n};
        bit_now = load ? a[W-1] : a_sh[W-1];
        t0      = load ? '0 : {acc, 1'b0};
        t1      = (t0 >= nx) ? t0 - nx : t0;
        t2      = bit_now ? t1 + {1'b0, b} : t1;
        r       = (t2 >= nx) ? W'(t2 - nx) : W'(t2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            a_sh <= '0;
        end else begin
            acc  <= r;
            a_sh <= load ? {a[W-2:0], 1'b0} : {a_sh[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/top_level_dec.sv
// RSA decryption m = c^d mod n: right-to-left square-and-multiply over two serial modular multipliers.
module top_level_dec
    import top_level_dec_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] cipher,
    input  logic [W-1:0] d_key,
    input  logic [W-1:0] n,
    output logic [W-1:0] m,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   c_r, n_r, exp_r, base, result;
    logic [W-1:0]   p_r, s_r, sq_a, sq_b;
    logic           last, mm_load, small_n;

    assign last    = (cnt == CW'(W - 1));
    assign mm_load = (cnt == '0);
    assign small_n = (n < W'(2));
    assign busy    = (state == REDUCE) || (state == CHECK) || (state == EXP);
    assign done    = (state == DONE);

    // The squaring unit doubles as the reducer: cipher*1 mod n handles cipher >= n.
    assign sq_a = (state == REDUCE) ? c_r : base;
    assign sq_b = (state == REDUCE) ? W'(1) : base;

    mod_mult #(.W(W)) u_prod (
        .clk   (clk),
        .reset (reset),
        .load  (mm_load),
        .a     (result),
        .b     (base),
        .n     (n_r),
        .r     (p_r)
    );

    mod_mult #(.W(W)) u_sq (
        .clk   (clk),
        .reset (reset),
        .load  (mm_load),
        .a     (sq_a),
        .b     (sq_b),
        .n     (n_r),
        .r     (s_r)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // n < 2 goes through CHECK with exp = 0 and result = 0, so m = 0 lands one edge after launch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = small_n ? CHECK : REDUCE;
            REDUCE:  if (last) state_nx = CHECK;
            CHECK:   state_nx = (exp_r == '0) ? DONE : EXP;
            EXP:     if (last) state_nx = CHECK;
            DONE:    if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            c_r    <= '0;
            n_r    <= '0;
            exp_r  <= '0;
            base   <= '0;
            result <= '0;
            m      <= '0;
        end else begin
            cnt <= ((state == REDUCE || state == EXP) && !last) ? cnt + CW'(1) : '0;
            case (state)
                IDLE: if (start) begin
                    c_r    <= cipher;
                    n_r    <= n;
                    result <= small_n ? '0 : W'(1);
                    exp_r  <= small_n ? '0 : d_key;
                end
                REDUCE: if (last) base <= s_r;
                CHECK:  if (exp_r == '0) m <= result;
                EXP: if (last) begin
                    if (exp_r[0]) result <= p_r;
                    base  <= s_r;
                    exp_r <= exp_r >> 1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level_dec.sv
// Directed bench for top_level_dec: results, latency, reset abort and start handshake.
module tb_top_level_dec;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] cipher, d_key, n;
    logic [W-1:0] m;
    logic         busy, done;
    int           checks = 0;
    int           errors = 0;
    int           lat;
    longint       c_enc;

    top_level_dec #(.W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cipher (cipher),
        .d_key  (d_key),
        .n      (n),
        .m      (m),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference encryptor for the round trip.
    function automatic longint modexp(input longint b, input longint e, input longint md);
        longint r = 1;
        longint x = b % md;
        longint k = e;
        while (k > 0) begin
            if (k[0]) r = (r * x) % md;
            x = (x * x) % md;
            k = k >> 1;
        end
        return r;
    endfunction

    task automatic set_in(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] nn);
        cipher = c;
        d_key  = d;
        n      = nn;
    endtask

    // Drive inputs + start at a negedge; returns just after launch edge E0.
    task automatic launch(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] nn);
        @(negedge clk);
        set_in(c, d, nn);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_launch", W'(busy), W'(1));
    endtask

    // Counts rising edges until done is seen (bounded); the first edge after E0 may already be counted by caller.
    task automatic wait_done(output int edges, input int pre);
        edges = pre;
        while (!done && edges < 6000) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("done_reached", W'(done), W'(1));
    endtask

    task automatic to_idle();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_done_low", W'(done), W'(0));
        check("idle_busy_low", W'(busy), W'(0));
    endtask

    task automatic run(input string tag, input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic [W-1:0] nn, input logic [W-1:0] exp_m, input int exp_lat);
        launch(c, d, nn);
        wait_done(lat, 0);
        // launch already consumed up to the negedge after E0, so lat counts edges after E0.
        check({tag, "_m"}, m, exp_m);
        check({tag, "_lat"}, W'(lat), W'(exp_lat));
        check({tag, "_busy"}, W'(busy), W'(0));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        set_in(31, 7, 33);
        repeat (3) @(negedge clk);
        check("rst_m", m, 0);
        check("rst_done", W'(done), W'(0));
        check("rst_busy", W'(busy), W'(0));

        // Scenario 1: start held through reset; first edge after release is E0.
        reset = 1'b0;
        @(posedge clk);
        wait_done(lat, 0);
        check("s1_m", m, 4);
        check("s1_lat", W'(lat), W'(516));
        check("s1_busy", W'(busy), W'(0));

        // Start held through DONE: no relaunch, m stable.
        repeat (5) @(negedge clk);
        check("hold_done", W'(done), W'(1));
        check("hold_busy", W'(busy), W'(0));
        check("hold_m", m, 4);
        to_idle();
        check("idle_m_held", m, 4);

        run("s3", 64, 1, 33, 31, 258);
        to_idle();
        run("s4_d0", 5, 0, 33, 1, 129);
        to_idle();
        run("s4_n1", 5, 7, 1, 0, 1);
        to_idle();

        c_enc = modexp(920, 33, 2773);
        run("rt", W'(c_enc), 1617, 2773, 920, 1548);
        to_idle();

        // Scenario 5: async reset mid-EXP, then a clean rerun.
        launch(31, 7, 33);
        repeat (300) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("s5_rst_m", m, 0);
        check("s5_rst_done", W'(done), W'(0));
        check("s5_rst_busy", W'(busy), W'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        wait_done(lat, 0);
        check("s5_m", m, 4);
        check("s5_lat", W'(lat), W'(516));
        to_idle();

        // Scenario 6: inputs changed mid-run are ignored until a fresh launch.
        set_in(5, 0, 33);
        run("s6_pre", 5, 0, 33, 1, 129);
        to_idle();
        launch(31, 7, 33);
        repeat (50) @(posedge clk);
        @(negedge clk);
        set_in(64, 1, 33);
        start = 1'b1;
        check("s6_m_held", m, 1);
        wait_done(lat, 50);
        check("s6_m", m, 4);
        check("s6_lat", W'(lat), W'(516));
        to_idle();
        launch(cipher, d_key, n);
        check("s6_m_held2", m, 4);
        wait_done(lat, 0);
        check("s6_new_m", m, 31);
        check("s6_new_lat", W'(lat), W'(258));
        to_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
